accumulator_controller: RTL and testbench

Sequencer and storage owner for the output accumulator of the systolic array. Accepts one row of column results per beat from the array, accumulates them over a programmed number of K-passes into a small row buffer, then drains the finished rows to the downstream unified buffer over a valid/ready handshake. It is the single point that decides when the accumulator is written, added to, read out and released for the next tile.

---
 rtl/accumulator_ctrl_pkg.sv | 28 ++
 rtl/acc_row_buffer.sv | 48 ++++
 rtl/accumulator_controller.sv | 137 +++++++++++++
 tb/tb_accumulator_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_ctrl_pkg.sv
// ============================================================================
// accumulator_ctrl_pkg : shared types and helpers for the accumulator control
// Revision: 1.0
// ============================================================================
`default_nettype none

package accumulator_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_N      = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_DEPTH  = 4;
  localparam int PASS_W     = 4;

  // Bit offset of column `col` inside a packed row of `w`-bit lanes.
  function automatic int lane_lo(input int col, input int w);
    return col * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_row_buffer.sv
// ============================================================================
// acc_row_buffer : DEPTH x N accumulator rows, overwrite/add write port and
//                  combinational read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_row_buffer
  import accumulator_ctrl_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic                add,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [N*DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [N*ACC_W-1:0]  rdata
);

  logic [N*ACC_W-1:0] mem [DEPTH];

  // Sums truncate to ACC_W, giving modulo-2^ACC_W wrap without saturation.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < N; c++) begin
        if (add) begin
          mem[waddr][lane_lo(c, ACC_W) +: ACC_W] <=
            mem[waddr][lane_lo(c, ACC_W) +: ACC_W] +
            ACC_W'(wdata[lane_lo(c, DATA_W) +: DATA_W]);
        end else begin
          mem[waddr][lane_lo(c, ACC_W) +: ACC_W] <=
            ACC_W'(wdata[lane_lo(c, DATA_W) +: DATA_W]);
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/accumulator_controller.sv
// ============================================================================
// accumulator_controller : sequences K-pass accumulation into the row buffer
//                          and drains finished rows over valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module accumulator_controller
  import accumulator_ctrl_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(DEPTH+1)-1:0]   num_rows,
  input  logic [PASS_W-1:0]            num_passes,
  input  logic                         in_valid,
  input  logic [N*DATA_W-1:0]          in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [N*ACC_W-1:0]           out_data,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);

  localparam int ROW_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state;
  logic [IDX_W-1:0]   wr_row;
  logic [IDX_W-1:0]   rd_row;
  logic [IDX_W-1:0]   last_row;
  logic [PASS_W-1:0]  pass;
  logic [PASS_W-1:0]  last_pass;
  logic [N*ACC_W-1:0] rd_data;
  logic               beat;
  logic               cfg_ok;

  assign beat   = in_valid && in_ready;
  assign cfg_ok = (num_rows != '0) && (num_rows <= ROW_W'(DEPTH)) && (num_passes != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_row    <= '0;
      rd_row    <= '0;
      last_row  <= '0;
      pass      <= '0;
      last_pass <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              last_row  <= IDX_W'(num_rows - ROW_W'(1));
              last_pass <= num_passes - PASS_W'(1);
              wr_row    <= '0;
              rd_row    <= '0;
              pass      <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              state     <= FILL;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        FILL: begin
          if (beat) begin
            if (wr_row == last_row) begin
              wr_row <= '0;
              if (pass == last_pass) begin
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                rd_row    <= '0;
                state     <= DRAIN;
              end else begin
                pass <= pass + PASS_W'(1);
              end
            end else begin
              wr_row <= wr_row + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_row == last_row) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              rd_row <= rd_row + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  acc_row_buffer #(
    .N      (N),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (beat),
    .add   (pass != '0),
    .waddr (wr_row),
    .wdata (in_data),
    .raddr (rd_row),
    .rdata (rd_data)
  );

  // Buffer contents are undefined until written, so mask them outside DRAIN.
  assign out_data = out_valid ? rd_data : '0;
  assign out_last = out_valid && (rd_row == last_row);

endmodule

`default_nettype wire

// File: tb/tb_accumulator_controller.sv
// ============================================================================
// tb_accumulator_controller : scoreboard bench for accumulator_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_accumulator_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  num_rows;
  logic [3:0]  num_passes;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy, done, cfg_err;

  // Narrow instance used to observe accumulator wrap.
  logic        start8;
  logic [1:0]  rows8;
  logic [3:0]  passes8;
  logic        in_valid8;
  logic [7:0]  in_data8;
  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  out_data8;
  logic        out_last8;
  logic        out_ready8;
  logic        busy8, done8, cfg_err8;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb[$];
  logic [8:0]  sb8[$];
  logic [15:0] bq[$];
  logic        done_pend = 1'b0;

  always #5 clk = ~clk;

  accumulator_controller #(.N(2), .DATA_W(8), .ACC_W(16), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .num_passes(num_passes), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  accumulator_controller #(.N(1), .DATA_W(8), .ACC_W(8), .DEPTH(2)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .num_rows(rows8),
    .num_passes(passes8), .in_valid(in_valid8), .in_data(in_data8),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8),
    .out_last(out_last8), .out_ready(out_ready8), .busy(busy8), .done(done8),
    .cfg_err(cfg_err8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pk(input int c0, input int c1);
    return {8'(c1), 8'(c0)};
  endfunction

  function automatic logic [32:0] row(input int c0, input int c1, input bit last);
    return {last, 16'(c1), 16'(c0)};
  endfunction

  // Monitor: compares every presented row against the scoreboard head.
  always @(negedge clk) begin
    if (done_pend) begin
      check("done_pulse", 64'(done), 64'd1);
      check("busy_after_done", 64'(busy), 64'd0);
      done_pend = 1'b0;
    end else if (done) begin
      check("spurious_done", 64'(done), 64'd0);
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_row", 64'(out_valid), 64'd0);
      end else begin
        check("row_data", 64'(out_data), 64'(sb[0][31:0]));
        check("row_last", 64'(out_last), 64'(sb[0][32]));
        if (out_ready) begin
          if (sb[0][32]) done_pend = 1'b1;
          void'(sb.pop_front());
        end
      end
    end
    if (out_valid8) begin
      if (sb8.size() == 0) begin
        check("unexpected_row8", 64'(out_valid8), 64'd0);
      end else begin
        check("row8_data", 64'(out_data8), 64'(sb8[0][7:0]));
        check("row8_last", 64'(out_last8), 64'(sb8[0][8]));
        if (out_ready8) void'(sb8.pop_front());
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic run_tile(input int r, input int p, input bit bp);
    num_rows = 3'(r); num_passes = 4'(p); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_on_start", 64'(busy), 64'd1);
    check("in_ready_on_start", 64'(in_ready), 64'd1);
    foreach (bq[i]) begin
      in_valid = 1'b1; in_data = bq[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    bq.delete();
    check("out_valid_after_fill", 64'(out_valid), 64'd1);
    if (bp) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("held_no_done", 64'(done), 64'd0);
      out_ready = 1'b1;
    end
    wait_idle("tile_timeout");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_rows = '0; num_passes = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    start8 = 1'b0; rows8 = '0; passes8 = '0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single pass, two rows.
    bq = '{pk(3, 5), pk(7, 9)};
    sb.push_back(row(3, 5, 0)); sb.push_back(row(7, 9, 1));
    run_tile(2, 1, 0);

    // Three passes; started the cycle after done.
    bq = '{pk(1, 2), pk(10, 20), pk(1, 2), pk(10, 20), pk(1, 2), pk(10, 20)};
    sb.push_back(row(3, 6, 0)); sb.push_back(row(30, 60, 1));
    run_tile(2, 3, 0);

    // Maximum passes of maximum data.
    for (int i = 0; i < 15; i++) bq.push_back(pk(255, 255));
    sb.push_back(row(3825, 3825, 1));
    run_tile(1, 15, 0);

    // Backpressure on row 1.
    bq = '{pk(1, 2), pk(3, 4)};
    sb.push_back(row(1, 2, 0)); sb.push_back(row(3, 4, 1));
    run_tile(2, 1, 1);

    // Illegal configurations leave the controller idle.
    num_rows = 3'd0; num_passes = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_err_rows0", 64'(cfg_err), 64'd1);
    check("busy_rows0", 64'(busy), 64'd0);
    num_rows = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rows5", 64'(busy), 64'd0);
    num_rows = 3'd1; num_passes = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_pass0", 64'(busy), 64'd0);

    // Legal start afterwards, zero-valued data.
    bq = '{pk(0, 0)};
    sb.push_back(row(0, 0, 1));
    run_tile(1, 1, 0);
    check("cfg_err_sticky", 64'(cfg_err), 64'd1);

    // Reset after one of four beats.
    num_rows = 3'd4; num_passes = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = pk(9, 9);
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_cfg_err", 64'(cfg_err), 64'd0);
    reset = 1'b0;

    // Fresh four-row tile over two passes.
    for (int pp = 0; pp < 2; pp++)
      for (int rr = 1; rr <= 4; rr++) bq.push_back(pk(rr, rr * 10));
    for (int rr = 1; rr <= 4; rr++) sb.push_back(row(2 * rr, 20 * rr, rr == 4));
    run_tile(4, 2, 0);

    // Reset and start in the same cycle: reset wins.
    num_rows = 3'd1; num_passes = 4'd1; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    check("rst_beats_start", 64'(busy), 64'd0);

    // 8-bit accumulator wraps: 200 + 100 = 300 mod 256 = 44.
    rows8 = 2'd1; passes8 = 4'd2; start8 = 1'b1;
    sb8.push_back({1'b1, 8'd44});
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy8_on_start", 64'(busy8), 64'd1);
    in_valid8 = 1'b1; in_data8 = 8'd200;
    @(posedge clk); #1;
    in_data8 = 8'd100;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    for (int i = 0; i < 50 && busy8; i++) begin
      @(posedge clk); #1;
    end
    check("tile8_timeout", 64'(busy8), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("sb8_drained", 64'(sb8.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
